// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the sequential ALU and its iterative multiply/divide unit.
//   - Opcode encodings OP_AND .. OP_REMU (13..15 are illegal).
//   - FSM state type for the top-level sequencer.
//   - A helper that identifies the opcodes that may need the iterative unit.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the opcodes that run on the iterative unit.
    // A zero B operand still short-circuits these to a single-cycle result.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: WIDTH-step unsigned shift-add multiplier / restoring divider.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load operands and begin WIDTH iterations
//   is_div            1 = divide (quotient/remainder), 0 = multiply
//   a, b              multiplicand/multiplier or dividend/divisor
//   done              high during the cycle whose edge completes the last iteration
//   prod_hi, prod_lo  product halves after the current iteration
//   quot, rem         quotient and remainder after the current iteration
// The result ports show the state *after* the step taken on the coming edge,
// so they hold the final answer exactly while done is high.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic             busy;
    logic             mode_div;
    logic [SHW-1:0]   cnt;
    // Multiply: acc = running high half, shreg = multiplier shifting out
    // right while product low bits shift in, opnd = multiplicand.
    // Divide: acc = partial remainder, shreg = dividend shifting out left
    // while quotient bits shift in, opnd = divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sh_next;

    // One iteration of whichever algorithm is active. The restoring divider
    // keeps the trial difference only when it did not go negative, which
    // the top bit of the (WIDTH+1)-bit subtraction tells us.
    always_comb begin
        sum      = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        trial    = {acc, shreg[WIDTH-1]};
        diff     = trial - {1'b0, opnd};
        acc_next = sum[WIDTH:1];
        sh_next  = {sum[0], shreg[WIDTH-1:1]};
        if (mode_div) begin
            acc_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            sh_next  = {shreg[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    // Operand load on start, then one step per clock until the counter has
    // covered 0..WIDTH-1. Reset drops any iteration in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            mode_div <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            mode_div <= is_div;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (busy) begin
            acc   <= acc_next;
            shreg <= sh_next;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == LAST);
    assign prod_hi = acc_next;
    assign prod_lo = sh_next;
    assign quot    = sh_next;
    assign rem     = acc_next;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with iterative unsigned multiply/divide.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         operand handshake (ALU_OP, A, B captured on accept)
//   ALU_OP [3:0], A, B          operation and operands
//   out_valid / out_ready       result handshake; result held until taken
//   F                           registered result
//   ZF, SF, PF, CF, OF          registered flags
//   err                         illegal opcode or divide by zero
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             ZF,
    output logic             SF,
    output logic             PF,
    output logic             CF,
    output logic             OF,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             iter_start;
    logic [3:0]       op_q;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_f;
    logic             sc_cf;
    logic             sc_of;
    logic             sc_err;

    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_quot;
    logic [WIDTH-1:0] md_rem;
    logic [WIDTH-1:0] it_f;
    logic             it_cf;

    logic             load;
    logic [WIDTH-1:0] ld_f;
    logic             ld_cf;
    logic             ld_of;
    logic             ld_err;

    // A new op can enter while idle, or in the same edge that the consumer
    // retires the previous result, which gives one op per cycle.
    assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign iter_start = accept && is_iter_op(ALU_OP) && (B != '0);
    assign out_valid  = (state == ST_DONE);
    assign shamt      = B[SHW-1:0];

    // Single-cycle datapath straight from the offered operands; its result
    // is registered on the accept edge. The MULU/DIVU/REMU arms only matter
    // when B is zero, since any other B goes to the iterative unit instead.
    always_comb begin
        sc_f     = '0;
        sc_cf    = 1'b0;
        sc_of    = 1'b0;
        sc_err   = 1'b0;
        add_full = {1'b0, A} + {1'b0, B};
        sub_res  = A - B;
        case (ALU_OP)
            OP_AND: sc_f = A & B;
            OP_OR:  sc_f = A | B;
            OP_XOR: sc_f = A ^ B;
            OP_NOR: sc_f = ~(A | B);
            OP_ADD: begin
                sc_f  = add_full[WIDTH-1:0];
                sc_cf = add_full[WIDTH];
                sc_of = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_f  = sub_res;
                sc_cf = (A < B);
                sc_of = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  sc_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  sc_f = A << shamt;
            OP_SRL:  sc_f = A >> shamt;
            OP_SRA:  sc_f = $signed(A) >>> shamt;
            OP_MULU: sc_f = '0;
            OP_DIVU: begin
                sc_f   = '1;
                sc_err = 1'b1;
            end
            OP_REMU: begin
                sc_f   = A;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (iter_start),
        .is_div  (ALU_OP != OP_MULU),
        .a       (A),
        .b       (B),
        .done    (md_done),
        .prod_hi (md_hi),
        .prod_lo (md_lo),
        .quot    (md_quot),
        .rem     (md_rem)
    );

    // Pick the iterative result for the op that was captured when CALC began.
    always_comb begin
        it_f  = md_lo;
        it_cf = 1'b0;
        case (op_q)
            OP_MULU: begin
                it_f  = md_lo;
                it_cf = |md_hi;
            end
            OP_DIVU: it_f = md_quot;
            OP_REMU: it_f = md_rem;
            default: it_f = md_lo;
        endcase
    end

    // Results are written either on a single-cycle accept or on the edge
    // that finishes the last iteration.
    always_comb begin
        load   = (accept && !iter_start) || ((state == ST_CALC) && md_done);
        ld_f   = sc_f;
        ld_cf  = sc_cf;
        ld_of  = sc_of;
        ld_err = sc_err;
        if (state == ST_CALC) begin
            ld_f   = it_f;
            ld_cf  = it_cf;
            ld_of  = it_cf;
            ld_err = 1'b0;
        end
    end

    // Output registers; flags come from the value being written so they
    // always describe the F that is presented alongside them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F   <= '0;
            ZF  <= 1'b0;
            SF  <= 1'b0;
            PF  <= 1'b0;
            CF  <= 1'b0;
            OF  <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            F   <= ld_f;
            ZF  <= (ld_f == '0);
            SF  <= ld_f[WIDTH-1];
            PF  <= ~^ld_f;
            CF  <= ld_cf;
            OF  <= ld_of;
            err <= ld_err;
        end
    end

    // Remember which iterative op is running so the right result is chosen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_AND;
        end else if (iter_start) begin
            op_q <= ALU_OP;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE with out_ready behaves like IDLE when a new
    // op is offered on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = iter_start ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                if (md_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = iter_start ? ST_CALC : ST_DONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32) against an
// arithmetic reference model of the opcode rules.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] F;
    logic        ZF, SF, PF, CF, OF, err;

    int n_vec  = 0;
    int n_miss = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_OP    (ALU_OP),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .ZF        (ZF),
        .SF        (SF),
        .PF        (PF),
        .CF        (CF),
        .OF        (OF),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: returns {F, ZF, SF, PF, CF, OF, err}.
    function automatic logic [37:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned wide;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s;
        int sh = int'(b[4:0]);
        logic [31:0] f = 32'd0;
        logic cf = 1'b0, of = 1'b0, e = 1'b0;
        case (op)
            4'd0: f = a & b;
            4'd1: f = a | b;
            4'd2: f = a ^ b;
            4'd3: f = ~(a | b);
            4'd4: begin
                wide = ua + ub; f = wide[31:0]; cf = wide[32];
                s = sa + sb; of = (s != longint'($signed(f)));
            end
            4'd5: begin
                wide = ua - ub; f = wide[31:0]; cf = (ua < ub);
                s = sa - sb; of = (s != longint'($signed(f)));
            end
            4'd6: f = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: begin wide = ua * (64'd1 << sh); f = wide[31:0]; end
            4'd8: f = 32'(ua / (64'd1 << sh));
            4'd9: begin s = sa >>> sh; f = s[31:0]; end
            4'd10: begin
                wide = ua * ub; f = wide[31:0];
                cf = (wide[63:32] != 32'd0); of = cf;
            end
            4'd11: if (b == 0) begin f = 32'hFFFF_FFFF; e = 1'b1; end else f = 32'(ua / ub);
            4'd12: if (b == 0) begin f = a; e = 1'b1; end else f = 32'(ua % ub);
            default: e = 1'b1;
        endcase
        return {f, (f == 32'd0), f[31], ($countones(f) % 2 == 0), cf, of, e};
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd10 || op == 4'd11 || op == 4'd12) && b != 0) return 33;
        return 1;
    endfunction

    // Drives one transaction, scrambles the inputs after accept, waits for
    // out_valid (bounded), samples the result and retires it.
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [37:0] got, output int lat,
                                  output bit ready_leak, output bit accepted);
        @(negedge clk);
        ALU_OP = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        accepted = in_ready;
        @(posedge clk);
        lat = 1;
        ready_leak = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; A = $urandom; B = $urandom; ALU_OP = 4'($urandom);
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = {F, ZF, SF, PF, CF, OF, err};
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Reset values while rst_n is held low, then release.
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALU_OP = 4'd0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({F, ZF, SF, PF, CF, OF, err} !== 38'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", {F, ZF, SF, PF, CF, OF, err}, 38'd0);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Worked examples with known results, plus model flags and latency.
    task automatic test_directed();
        logic [3:0]  d_op [8] = '{4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd11, 4'd15};
        logic [31:0] d_a  [8] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h0001FFFF,
                                  32'h12345678, 32'h12345678, 32'h88888888, 32'hDEADBEEF};
        logic [31:0] d_b  [8] = '{32'h00000001, 32'h0000FFFF, 32'h0000001F, 32'hFFFF0001,
                                  32'h00000010, 32'h00000010, 32'h00000000, 32'h00000001};
        logic [31:0] d_f  [8] = '{32'h00000000, 32'hFFFF0001, 32'hFFFFFFFF, 32'h0002FFFF,
                                  32'h01234567, 32'h00000008, 32'hFFFFFFFF, 32'h00000000};
        logic [37:0] got;
        logic [37:0] exp_r;
        int lat;
        bit leak, acc;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(d_op[i], d_a[i], d_b[i], got, lat, leak, acc);
            exp_r = model_result(d_op[i], d_a[i], d_b[i]);
            n_vec++;
            if (got[37:6] !== d_f[i]) begin
                n_miss++;
                $display("[TB] FAIL directed_f[%0d]: got %h expected %h", i, got[37:6], d_f[i]);
            end
            n_vec++;
            if (got !== exp_r) begin
                n_miss++;
                $display("[TB] FAIL directed_flags[%0d]: got %h expected %h", i, got, exp_r);
            end
            n_vec++;
            if (lat !== model_latency(d_op[i], d_b[i])) begin
                n_miss++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, model_latency(d_op[i], d_b[i]));
            end
            n_vec++;
            if (leak !== 1'b0 || acc !== 1'b1) begin
                n_miss++;
                $display("[TB] FAIL directed_ready[%0d]: got leak=%b acc=%b expected leak=0 acc=1", i, leak, acc);
            end
        end
    endtask

    // Random opcodes and operands, with zero divisors mixed in.
    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [37:0] got, exp_r;
        int lat;
        bit leak, acc;
        for (int i = 0; i < 50; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            apply_stimulus(op, a, b, got, lat, leak, acc);
            exp_r = model_result(op, a, b);
            n_vec++;
            if (got !== exp_r || lat !== model_latency(op, b) || leak || !acc) begin
                n_miss++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d leak %b acc %b expected %h lat %0d",
                         i, op, a, b, got, lat, leak, acc, exp_r, model_latency(op, b));
            end
        end
    endtask

    // Hold the result under backpressure, then retire it while accepting XOR.
    task automatic test_backpressure();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [37:0] held = model_result(4'd4, a, b);
        @(negedge clk);
        ALU_OP = 4'd4; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if ({F, ZF, SF, PF, CF, OF, err} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_miss++;
                $display("[TB] FAIL backpressure_hold[%0d]: got %h rdy %b ov %b expected %h rdy 0 ov 1",
                         c, {F, ZF, SF, PF, CF, OF, err}, in_ready, out_valid, held);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; ALU_OP = 4'd2; A = 32'hF0F0F0F0; B = 32'h0F0F0F0F;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL backpressure_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || F !== 32'hFFFFFFFF || {F, ZF, SF, PF, CF, OF, err} !== model_result(4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F)) begin
            n_miss++;
            $display("[TB] FAIL backpressure_next: got ov %b %h expected ov 1 %h", out_valid,
                     {F, ZF, SF, PF, CF, OF, err}, model_result(4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F));
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL backpressure_retire: got ov %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    // Stream of single-cycle ops at one per clock.
    task automatic test_back_to_back();
        logic [3:0]  ops [20];
        logic [31:0] as  [20];
        logic [31:0] bs  [20];
        logic [37:0] exp_r;
        for (int i = 0; i < 20; i++) begin
            ops[i] = 4'($urandom_range(0, 9));
            as[i]  = $urandom;
            bs[i]  = $urandom;
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        ALU_OP = ops[0]; A = as[0]; B = bs[0];
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_r = model_result(ops[i], as[i], bs[i]);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || {F, ZF, SF, PF, CF, OF, err} !== exp_r) begin
                n_miss++;
                $display("[TB] FAIL back_to_back[%0d] op=%0d: got ov %b rdy %b %h expected ov 1 rdy 1 %h",
                         i, ops[i], out_valid, in_ready, {F, ZF, SF, PF, CF, OF, err}, exp_r);
            end
            if (i < 19) begin
                ALU_OP = ops[i+1]; A = as[i+1]; B = bs[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL back_to_back_drain: got ov %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    // Reset during MULU iteration 10 aborts the op; a later ADD works.
    task automatic test_reset_mid_calc();
        logic [37:0] got;
        int lat;
        bit leak, acc;
        bit leaked_result = 1'b0;
        @(negedge clk);
        ALU_OP = 4'd10; A = 32'h0001FFFF; B = 32'hFFFF0001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {F, ZF, SF, PF, CF, OF, err} !== 38'd0) begin
            n_miss++;
            $display("[TB] FAIL mid_reset_async: got ov %b rdy %b %h expected ov 0 rdy 1 0",
                     out_valid, in_ready, {F, ZF, SF, PF, CF, OF, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) leaked_result = 1'b1;
        end
        out_ready = 1'b0;
        n_vec++;
        if (leaked_result !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL mid_reset_no_result: got %b expected 0", leaked_result);
        end
        apply_stimulus(4'd4, 32'd1, 32'd1, got, lat, leak, acc);
        n_vec++;
        if (got !== model_result(4'd4, 32'd1, 32'd1) || got[37:6] !== 32'd2 || lat !== 1 || !acc) begin
            n_miss++;
            $display("[TB] FAIL mid_reset_add: got %h lat %0d acc %b expected %h lat 1 acc 1",
                     got, lat, acc, model_result(4'd4, 32'd1, 32'd1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational 32-bit ALU. It adds a WIDTH parameter, registered results and flags, valid/ready flow control, right shifts, and iterative unsigned multiply/divide/remainder. It sits between operand fetch and writeback and holds each result until the consumer takes it.

## Interface
- WIDTH, 32, operand/result width; power of 2, ≥ 4; SHW = $clog2(WIDTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands/op offered
- in_ready  out  1  block can accept this cycle
- ALU_OP  in  4  operation code
- A, B  in  WIDTH  operands
- out_valid  out  1  F/flags valid
- out_ready  in  1  consumer accepts result
- F  out  WIDTH  result
- ZF, SF, PF, CF, OF  out  1 each  flags
- err  out  1  illegal op or divide by zero

## Operation
- Opcodes (unsigned unless stated):
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 4 ADD, 5 SUB
  - 6 SLT: signed, F = {0…, A<B}
  - 7 SLL, 8 SRL, 9 SRA: amount B[SHW-1:0]
  - 10 MULU: low WIDTH bits of A*B
  - 11 DIVU, 12 REMU
  - 13–15 illegal: F=0, err=1
- Flags, computed from final F for every op: ZF=(F==0); SF=F[WIDTH-1]; PF=~^F (1 when the count of ones is even).
- CF:
  - ADD: carry-out.
  - SUB: borrow, i.e. A<B unsigned.
  - MULU: upper product half ≠ 0.
  - All other ops: 0.
- OF:
  - ADD/SUB: signed overflow.
  - MULU: same value as CF.
  - All other ops: 0.
- Divide by zero: DIVU F = all ones; REMU F = A; err=1; no iteration.
- FSM states:
  - IDLE: in_ready=1. On accept, a single-cycle op goes to DONE; MULU/DIVU/REMU with B≠0 goes to CALC.
  - CALC: iteration counter runs 0..WIDTH-1. MULU is shift-add. DIVU/REMU are restoring division. When the count reaches WIDTH-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, unless a new op is accepted on the same edge (then behave as an IDLE accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- A, B and ALU_OP are captured on accept. Input changes after accept have no effect.

## Timing
- Reset values:
  - state IDLE, out_valid=0, F=0, err=0.
  - All flags 0; ZF=0 although F=0 (flags are registered, not derived during reset).
  - in_ready=1.
- Single-cycle ops, divide by zero and illegal ops: out_valid rises on the edge after accept (latency 1).
- MULU/DIVU/REMU (B≠0): out_valid rises WIDTH+1 edges after accept.
- In DONE with out_ready=0, F, flags and err hold stable and in_ready=0.
- Back-to-back: a DONE&&out_ready&&in_valid edge retires the old result and accepts the new op. Single-cycle ops then sustain 1 op/cycle.
- Reset asserted mid-CALC or mid-DONE aborts immediately: no result is delivered, and outputs take reset values asynchronously.
- The SHW shift amount takes only the low bits of B; upper bits are ignored.

## Structure
- Package alu_pkg: opcode localparams (OP_AND…OP_REMU), FSM state encoding.
- Sub-module alu_iter_muldiv: WIDTH-cycle shift-add multiplier / restoring divider with start/done. It returns the product high/low halves, quotient and remainder.
- The top holds the combinational single-cycle datapath, flag logic, FSM and output registers.

## Test plan
All scenarios use WIDTH=32.
- ADD A=FFFFFFFF, B=00000001 → F=00000000, ZF=1, CF=1, OF=0, SF=0, PF=1, err=0; out_valid one edge after accept.
- SUB A=00000000, B=0000FFFF → F=FFFF0001, CF=1, SF=1, OF=0, ZF=0, PF=0. Then SRA A=80000000, B=0000001F → F=FFFFFFFF.
- MULU A=0001FFFF, B=FFFF0001 → F=0002FFFF, CF=OF=1; out_valid exactly 33 edges after accept; in_ready=0 throughout CALC.
- DIVU A=12345678, B=00000010 → F=01234567. REMU on the same operands → F=00000008. DIVU A=88888888, B=0 → F=FFFFFFFF, err=1, latency 1. ALU_OP=1111 → F=0, ZF=1, err=1.
- Backpressure: hold out_ready=0 for 5 cycles → F and flags stable, in_ready=0. Then out_ready=1 with a new XOR op (A=F0F0F0F0, B=0F0F0F0F) offered on the same edge → accepted, next F=FFFFFFFF.
- Assert rst_n=0 at CALC iteration 10 of MULU → out_valid=0 immediately, no result delivered. After release, in_ready=1, and the following ADD 1+1 gives F=2.
